// File: rtl/icache_refill_pkg.sv
// Shared types and default widths for the L1 instruction-cache refill writer.
package icache_refill_pkg;

  localparam int DEF_ADDR_WIDTH   = 5;
  localparam int DEF_OFFSET_WIDTH = 2;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_TAG_WIDTH    = 20;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    COMMIT
  } state_t;

  typedef struct packed {
    logic                     valid;
    logic [DEF_TAG_WIDTH-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/icache_refill_writer.sv
// Refill sequencer: requests a missed line from L2, streams its beats into the
// data array one word per cycle, and commits the tag entry after the last word.
module icache_refill_writer
  import icache_refill_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
  localparam int IDX_W       = ADDR_WIDTH - OFFSET_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       refill_req_valid_i,
  output logic                       refill_req_ready_o,
  input  logic [IDX_W-1:0]           refill_req_index_i,
  input  logic [TAG_WIDTH-1:0]       refill_req_tag_i,
  output logic                       l2_req_valid_o,
  input  logic                       l2_req_ready_i,
  output logic [TAG_WIDTH+IDX_W-1:0] l2_req_line_o,
  input  logic                       l2_rsp_valid_i,
  output logic                       l2_rsp_ready_o,
  input  logic [DATA_WIDTH-1:0]      l2_rsp_data_i,
  output logic                       rf_we_o,
  output logic [ADDR_WIDTH-1:0]      rf_waddr_o,
  output logic [DATA_WIDTH-1:0]      rf_wdata_o,
  output logic                       tag_we_o,
  output logic [IDX_W-1:0]           tag_waddr_o,
  output logic [TAG_WIDTH:0]         tag_wdata_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int WPL = 2 ** OFFSET_WIDTH;
  localparam logic [OFFSET_WIDTH-1:0] CNT_LAST = OFFSET_WIDTH'(WPL - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [OFFSET_WIDTH-1:0] cnt;
  logic [IDX_W-1:0]        idx_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic                    req_fire;
  logic                    l2_req_fire;
  logic                    beat_fire;
  logic                    last_beat;

  assign req_fire    = refill_req_valid_i & (state == IDLE);
  assign l2_req_fire = l2_req_ready_i & (state == REQ);
  assign beat_fire   = l2_rsp_valid_i & (state == DATA);
  assign last_beat   = beat_fire & (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (refill_req_valid_i) state_nxt = REQ;
      REQ:     if (l2_req_ready_i) state_nxt = DATA;
      DATA:    if (l2_rsp_valid_i && (cnt == CNT_LAST)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    refill_req_ready_o = (state == IDLE);
    l2_rsp_ready_o     = (state == DATA);
    busy_o             = (state != IDLE);
  end

  // Miss address is data, held for the whole refill; no reset needed.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      idx_q <= refill_req_index_i;
      tag_q <= refill_req_tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      rf_we_o        <= 1'b0;
      rf_waddr_o     <= '0;
      rf_wdata_o     <= '0;
      tag_we_o       <= 1'b0;
      tag_waddr_o    <= '0;
      tag_wdata_o    <= '0;
      l2_req_valid_o <= 1'b0;
      l2_req_line_o  <= '0;
      done_o         <= 1'b0;
    end else begin
      rf_we_o  <= beat_fire;
      tag_we_o <= 1'b0;
      done_o   <= 1'b0;
      // Invalidate the entry up front so a half-written line can never hit.
      if (req_fire) begin
        tag_we_o       <= 1'b1;
        tag_waddr_o    <= refill_req_index_i;
        tag_wdata_o    <= {1'b0, refill_req_tag_i};
        l2_req_valid_o <= 1'b1;
        l2_req_line_o  <= {refill_req_tag_i, refill_req_index_i};
      end
      if (l2_req_fire) begin
        l2_req_valid_o <= 1'b0;
        cnt            <= '0;
      end
      if (beat_fire) begin
        rf_waddr_o <= {idx_q, cnt};
        rf_wdata_o <= l2_rsp_data_i;
        cnt        <= cnt + 1'b1;
      end
      if (last_beat) begin
        tag_we_o    <= 1'b1;
        tag_waddr_o <= idx_q;
        tag_wdata_o <= {1'b1, tag_q};
        done_o      <= 1'b1;
      end
    end
  end

endmodule
